mul_hilo_ctrl: RTL and testbench

Sequencing and result-register stage wrapped around the combinational 32×32 signed Booth multiplier. It latches the operands that drive the multiplier and holds them stable for a fixed settle window. It then captures the 64-bit product into the architectural HI/LO registers and signals completion to the datapath control unit. It also services direct HI/LO writes (mthi/mtlo) and exposes HI/LO for reads (mfhi/mflo).

---
 rtl/mul_hilo_ctrl.sv | 110 +++++++++++
 tb/tb_mul_hilo_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_ctrl.sv
// Operand latch, settle-window sequencer and HI/LO result registers that sit
// around a combinational 32x32 signed multiplier.
module mul_hilo_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] op_x,
    output logic [31:0] op_y,
    input  logic [63:0] prod_in,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wr_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    // Handshake: start is accepted on any edge where busy=0 and is dropped
    // (never queued) while busy=1; done pulses for exactly one cycle when
    // HI/LO hold the new product.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_op_x;
    logic [31:0] r_op_y;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_load;
    logic        w_capture;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = S_SETTLE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt  <= 4'd0;
            r_op_x <= 32'd0;
            r_op_y <= 32'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else begin
            if (w_load) begin
                r_cnt  <= CNT_INIT;
                r_op_x <= a_in;
                r_op_y <= b_in;
            end else if (r_state == S_SETTLE && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Product capture takes priority; a same-edge mthi/mtlo is lost.
            if (w_capture) begin
                r_hi <= prod_in[63:32];
                r_lo <= prod_in[31:0];
            end else begin
                if (mthi) r_hi <= wr_data;
                if (mtlo) r_lo <= wr_data;
            end
        end
    end

    assign op_x      = r_op_x;
    assign op_y      = r_op_y;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign busy      = (r_state == S_SETTLE);
    assign done      = (r_state == S_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl: SETTLE=2 main instance plus a SETTLE=1
// instance, each driving its own behavioural multiplier.
module tb_mul_hilo_ctrl;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wr_data;

    logic [31:0] op_x, op_y, hi, lo;
    logic [63:0] prod;
    logic        busy, done;
    logic [1:0]  dbg_state;

    logic [31:0] op_x1, op_y1, hi1, lo1;
    logic [63:0] prod1;
    logic        busy1, done1;
    logic [1:0]  dbg_state1;

    int total;
    int bad;

    // Low 64 bits of the product of sign-extended operands = signed product.
    assign prod  = {{32{op_x[31]}}, op_x} * {{32{op_y[31]}}, op_y};
    assign prod1 = {{32{op_x1[31]}}, op_x1} * {{32{op_y1[31]}}, op_y1};

    mul_hilo_ctrl #(.SETTLE(2)) u_dut (
        .clk(clk), .clr(clr), .start(start), .a_in(a_in), .b_in(b_in),
        .op_x(op_x), .op_y(op_y), .prod_in(prod), .mthi(mthi), .mtlo(mtlo),
        .wr_data(wr_data), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    mul_hilo_ctrl #(.SETTLE(1)) u_dut1 (
        .clk(clk), .clr(clr), .start(start), .a_in(a_in), .b_in(b_in),
        .op_x(op_x1), .op_y(op_y1), .prod_in(prod1), .mthi(mthi), .mtlo(mtlo),
        .wr_data(wr_data), .hi(hi1), .lo(lo1), .busy(busy1), .done(done1),
        .dbg_state(dbg_state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
        #2;
        total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL reset_hilo: hi=%h lo=%h want 0", hi, lo); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL reset_ctrl: busy=%b done=%b st=%0d want 0", busy, done, dbg_state); end
        total++; if (op_x !== 32'd0 || op_y !== 32'd0) begin bad++; $display("FAIL reset_ops: x=%h y=%h want 0", op_x, op_y); end
        tick();
        clr = 1'b0;
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h12345678;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL reset_prewrite: hi=%h want 12345678", hi); end
        start = 1'b1; a_in = 32'd7; b_in = 32'hFFFFFFFD;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy_before: busy=%b want 1", busy); end
        #2;
        clr = 1'b1;
        #1;
        total++; if (hi !== 32'd0 || lo !== 32'd0 || op_x !== 32'd0 || op_y !== 32'd0) begin bad++; $display("FAIL reset_async_data: hi=%h lo=%h x=%h y=%h want 0", hi, lo, op_x, op_y); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_async_ctrl: busy=%b done=%b want 0", busy, done); end
        tick();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (done !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL reset_no_done[%0d]: done=%b st=%0d want 0/0", i, done, dbg_state); end
        end
    endtask

    task automatic test_basic();
        start = 1'b1; a_in = 32'd7; b_in = 32'hFFFFFFFD;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL basic_k: busy=%b done=%b want 1/0", busy, done); end
        total++; if (op_x !== 32'd7 || op_y !== 32'hFFFFFFFD) begin bad++; $display("FAIL basic_ops: x=%h y=%h want 7/fffffffd", op_x, op_y); end
        tick();
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL basic_k1: busy=%b done=%b want 1/0", busy, done); end
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL basic_k2: busy=%b done=%b want 0/1", busy, done); end
        total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL basic_result: hi=%h lo=%h want ffffffff/ffffffeb", hi, lo); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_pulse: done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_corner();
        start = 1'b1; a_in = 32'h80000000; b_in = 32'h80000000;
        tick(); start = 1'b0; tick(); tick();
        total++; if (done !== 1'b1 || hi !== 32'h40000000 || lo !== 32'h00000000) begin bad++; $display("FAIL corner_min: done=%b hi=%h lo=%h want 1/40000000/00000000", done, hi, lo); end
        tick();
        start = 1'b1; a_in = 32'hFFFFFFFF; b_in = 32'd1;
        tick(); start = 1'b0; tick(); tick();
        total++; if (done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL corner_neg1: done=%b hi=%h lo=%h want 1/ffffffff/ffffffff", done, hi, lo); end
        tick();
    endtask

    task automatic test_ignored_start();
        start = 1'b1; a_in = 32'd7; b_in = 32'hFFFFFFFD;
        tick();
        a_in = 32'd5; b_in = 32'd9;
        tick();
        start = 1'b0;
        total++; if (op_x !== 32'd7 || op_y !== 32'hFFFFFFFD) begin bad++; $display("FAIL ign_ops: x=%h y=%h want 7/fffffffd", op_x, op_y); end
        tick();
        total++; if (done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL ign_result: done=%b hi=%h lo=%h want 1/ffffffff/ffffffeb", done, hi, lo); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ign_single[%0d]: done=%b busy=%b want 0/0", i, done, busy); end
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; a_in = 32'd7; b_in = 32'hFFFFFFFD;
        tick();
        start = 1'b0;
        tick(); tick();
        total++; if (done !== 1'b1 || lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL b2b_first: done=%b lo=%h want 1/ffffffeb", done, lo); end
        start = 1'b1; a_in = 32'd100; b_in = 32'd200;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0 || op_x !== 32'd100) begin bad++; $display("FAIL b2b_accept: busy=%b done=%b x=%h want 1/0/64", busy, done, op_x); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_early: done=%b want 0", done); end
        tick();
        total++; if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'h00004E20) begin bad++; $display("FAIL b2b_second: done=%b hi=%h lo=%h want 1/0/00004e20", done, hi, lo); end
        tick(); tick();
        total++; if (op_x !== 32'd100 || op_y !== 32'd200 || dbg_state !== 2'd0) begin bad++; $display("FAIL b2b_hold: x=%h y=%h st=%0d want 64/c8/0", op_x, op_y, dbg_state); end
    endtask

    task automatic test_mthi_mtlo();
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hCAFEF00D;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        total++; if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) begin bad++; $display("FAIL mt_idle: hi=%h lo=%h want cafef00d", hi, lo); end
        start = 1'b1; a_in = 32'd7; b_in = 32'hFFFFFFFD;
        tick();
        start = 1'b0;
        mtlo = 1'b1; wr_data = 32'h11111111;
        tick();
        mtlo = 1'b0;
        total++; if (lo !== 32'h11111111 || hi !== 32'hCAFEF00D) begin bad++; $display("FAIL mt_settle: hi=%h lo=%h want cafef00d/11111111", hi, lo); end
        mthi = 1'b1; wr_data = 32'hDEADBEEF;
        tick();
        mthi = 1'b0;
        total++; if (done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mt_capture_wins: done=%b hi=%h lo=%h want 1/ffffffff/ffffffeb", done, hi, lo); end
        tick(); tick();
    endtask

    task automatic test_settle1();
        start = 1'b1; a_in = 32'd100; b_in = 32'd200;
        tick();
        start = 1'b0;
        total++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin bad++; $display("FAIL s1_k: busy=%b done=%b want 1/0", busy1, done1); end
        tick();
        total++; if (done1 !== 1'b1 || busy1 !== 1'b0 || hi1 !== 32'd0 || lo1 !== 32'h00004E20) begin bad++; $display("FAIL s1_capture: done=%b busy=%b hi=%h lo=%h want 1/0/0/00004e20", done1, busy1, hi1, lo1); end
        tick();
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL s1_pulse: done=%b want 0", done1); end
        tick(); tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_corner();
        test_ignored_start();
        test_back_to_back();
        test_mthi_mtlo();
        test_settle1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
